axi_pwm_multi_gen: RTL and testbench
====================================

Name: axi_pwm_multi_gen

Overview:
Parametrised multi-channel PWM generator; successor to the fixed 4-channel, 12-bit, fixed-period PWM interface. Adds channel count and width parameters, a programmable period, edge- or centre-aligned counting, per-channel output polarity and a global enable. All run-time settings go through shadow registers, so they apply only on period boundaries and never produce glitched pulses. Sits between the AXI register map (static config/duty inputs) and the board pins (LEDs / gate drivers).

Parameters:
CHANNELS, 4, number of PWM outputs (1..16)
WIDTH, 12, counter/period/duty width in bits (4..16)
DEFAULT_PERIOD, 4095, reset value of the shadow period (WIDTH bits)

Ports:
pwm_clk  input  1  PWM clock, all logic rising-edge
rstn  input  1  reset, asynchronous assert, active-low
enable  input  1  1 = run counter; 0 = hold outputs inactive
mode  input  1  0 = edge-aligned, 1 = centre-aligned
period  input  WIDTH  terminal count P
duty  input  CHANNELS*WIDTH  duty D per channel; channel i = bits [i*WIDTH +: WIDTH]
polarity  input  CHANNELS  per channel: 1 = invert output
pwm_out  output  CHANNELS  PWM outputs, registered
end_of_period  output  1  one-cycle pulse aligned with the last pwm_out sample of each period

Behaviour:
- Reset (rstn low, asynchronous): cnt=0, direction up; shadow P=DEFAULT_PERIOD, shadow D=0, shadow mode=0, shadow polarity=0. pwm_out=0 and end_of_period=0 immediately, with no clock edge required.
- Shadow load: when enable=0, all shadows (period, duty, mode, polarity) load every cycle. When enable=1, they load only in the cycle where internal eop=1.
- Edge mode: cnt runs 0,1,…,P, then 0. Period = P+1 cycles. eop=1 when cnt==P.
- Centre mode: cnt runs 0,1,…,P,P-1,…,1, then 0. Period = 2P cycles. eop=1 in the cycle whose next cnt is 0, i.e. cnt==1 on the down slope, or cnt==P==1.
- P=0 in either mode: cnt stays 0 and eop=1 every cycle.
- The count sequence after a boundary uses the newly loaded shadow P and mode. A mode change restarts at cnt=0, direction up.
- Compare per channel: active = (D_shadow > cnt); pwm_out[i] <= active XOR polarity_shadow[i]. Latency is 1 cycle from cnt to pwm_out.
- Active cycles per period:
  - Edge mode: min(D, P+1).
  - Centre mode: 0 if D=0, else 2·min(D,P+1)-1, capped at 2P. The active region is symmetric about cnt=0.
- D=0: always inactive. D>P: always active.
- end_of_period output = internal eop registered, so it is aligned with pwm_out.
- enable=0: cnt forced to 0, direction up, end_of_period=0, pwm_out = polarity_shadow (inactive level).
- enable 0→1: the first counted cycle has cnt=0. The first pwm_out update comes one cycle later.
- enable 1→0 mid-period: the period is abandoned on the next edge, with no completion of the current period.
- Arithmetic: cnt is WIDTH bits and never exceeds P, so there is no overflow. Comparisons are unsigned, full WIDTH.
- Reset asserted mid-period: behaves as at power-up. After release, operation restarts from cnt=0 with default shadows (loaded from the inputs while enable=0).

Test Plan:
1. Reset defaults: rstn low with no clock running, pwm_out previously toggling -> pwm_out=0 and end_of_period=0 immediately. Release with enable=0, polarity=0 -> outputs stay 0.
2. Edge mode, P=9, CHANNELS=4, D={3,0,10,12}, enable=1 -> per 10-cycle period: ch0 high 3 cycles, ch1 always 0, ch2 and ch3 always 1. end_of_period pulses every 10 cycles, coincident with the last sample of each period.
3. Centre mode, P=4, D ch0=2 -> 8-cycle period. ch0 high 3 consecutive cycles (cnt 1,0,1 across the boundary). end_of_period every 8 cycles. Also P=0 -> end_of_period high every cycle.
4. Shadow timing, edge mode: P=9, D ch0=3. Write D=7 and P=4 at cnt=5 -> remainder of the current period still uses D=3, P=9. The next period is 5 cycles with ch0 high 5 (D>P). No runt or extended pulse at the switch.
5. Polarity and enable: polarity=4'b0010, D ch1=3, P=9 -> ch1 low 3 cycles, high 7 per period. Drop enable -> next cycle ch1=1, others 0, end_of_period=0. Re-enable -> cnt restarts at 0.
6. Reset mid-operation: centre mode at cnt=3 on the down slope, pulse rstn low for 2 cycles -> outputs 0 asynchronously. After release with enable=1, the first period is edge mode with P=DEFAULT_PERIOD until the first boundary loads the input values.

Source files
------------

// File: rtl/axi_pwm_multi_gen.sv
// rtl/axi_pwm_multi_gen.sv - parametrised multi-channel PWM generator with shadowed settings
//
// Ports:
//   pwm_clk        PWM clock, rising edge
//   rstn           asynchronous active-low reset
//   enable         1 = count, 0 = hold outputs at inactive level
//   mode           0 = edge-aligned, 1 = centre-aligned
//   period         terminal count P
//   duty           per-channel duty D, channel i at [i*WIDTH +: WIDTH]
//   polarity       per-channel output inversion
//   pwm_out        registered PWM outputs
//   end_of_period  one-cycle pulse on the last pwm_out sample of each period

module axi_pwm_multi_gen #(
    parameter int          CHANNELS       = 4,
    parameter int          WIDTH          = 12,
    parameter int unsigned DEFAULT_PERIOD = 4095
) (
    input  logic                      pwm_clk,
    input  logic                      rstn,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic [CHANNELS-1:0]       polarity,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      end_of_period
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]          cnt;
    logic                      dir_down;
    logic [WIDTH-1:0]          p_sh;
    logic [CHANNELS*WIDTH-1:0] d_sh;
    logic                      mode_sh;
    logic [CHANNELS-1:0]       pol_sh;
    logic [CHANNELS-1:0]       active;
    logic                      eop;
    logic                      load;

    // Last cycle of the period: the cycle whose successor has cnt == 0.
    always_comb begin
        eop = 1'b0;
        if (p_sh == '0) begin
            eop = 1'b1;
        end else if (!mode_sh) begin
            eop = (cnt == p_sh);
        end else begin
            // P == 1 in centre mode turns around at the top, so cnt==1 going up also ends it.
            eop = (cnt == ONE) && (dir_down || (p_sh == ONE));
        end
    end

    always_comb begin
        active = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            active[i] = (d_sh[i*WIDTH +: WIDTH] > cnt);
        end
    end

    // Settings only change on a period boundary, or freely while stopped.
    assign load = !enable || eop;

    always_ff @(posedge pwm_clk or negedge rstn) begin
        if (!rstn) begin
            cnt           <= '0;
            dir_down      <= 1'b0;
            p_sh          <= WIDTH'(DEFAULT_PERIOD);
            d_sh          <= '0;
            mode_sh       <= 1'b0;
            pol_sh        <= '0;
            pwm_out       <= '0;
            end_of_period <= 1'b0;
        end else begin
            if (load) begin
                p_sh    <= period;
                d_sh    <= duty;
                mode_sh <= mode;
                pol_sh  <= polarity;
            end

            if (!enable) begin
                cnt           <= '0;
                dir_down      <= 1'b0;
                pwm_out       <= pol_sh;
                end_of_period <= 1'b0;
            end else begin
                // Compare uses the current shadows, so the last sample of a period
                // still reflects the old settings.
                pwm_out       <= active ^ pol_sh;
                end_of_period <= eop;

                if (eop) begin
                    cnt      <= '0;
                    dir_down <= 1'b0;
                end else if (!mode_sh) begin
                    cnt <= cnt + ONE;
                end else if (dir_down) begin
                    cnt <= cnt - ONE;
                end else if (cnt == p_sh) begin
                    cnt      <= cnt - ONE;
                    dir_down <= 1'b1;
                end else begin
                    cnt <= cnt + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_pwm_multi_gen.sv
// tb/tb_axi_pwm_multi_gen.sv - directed self-checking bench for axi_pwm_multi_gen

module tb_axi_pwm_multi_gen;

    localparam int CH = 4;
    localparam int W  = 12;

    logic              pwm_clk = 1'b0;
    logic              rstn    = 1'b0;
    logic              enable  = 1'b0;
    logic              mode    = 1'b0;
    logic [W-1:0]      period  = 12'd9;
    logic [CH*W-1:0]   duty    = '0;
    logic [CH-1:0]     polarity = '0;
    logic [CH-1:0]     pwm_out;
    logic              end_of_period;

    bit clk_run = 1'b1;
    int tests   = 0;
    int fails   = 0;

    int cseq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

    axi_pwm_multi_gen #(
        .CHANNELS(CH),
        .WIDTH(W),
        .DEFAULT_PERIOD(4095)
    ) dut (
        .pwm_clk(pwm_clk),
        .rstn(rstn),
        .enable(enable),
        .mode(mode),
        .period(period),
        .duty(duty),
        .polarity(polarity),
        .pwm_out(pwm_out),
        .end_of_period(end_of_period)
    );

    always #5 if (clk_run) pwm_clk = ~pwm_clk;

    // Stop, apply settings, let the shadows pick them up; ends on a falling edge.
    task automatic idle_cfg(input logic m, input logic [W-1:0] p,
                            input logic [CH*W-1:0] d, input logic [CH-1:0] pol);
        enable   = 1'b0;
        mode     = m;
        period   = p;
        duty     = d;
        polarity = pol;
        repeat (3) @(negedge pwm_clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge pwm_clk);
        tests++;
        if (pwm_out !== 4'b0000 || end_of_period !== 1'b0) begin
            fails++;
            $display("FAIL reset_state pwm_out=%b eop=%b exp 0000/0", pwm_out, end_of_period);
        end
        rstn = 1'b1;
        idle_cfg(1'b0, 12'd3, {36'd0, 12'd2}, 4'b0000);
        enable = 1'b1;
        @(negedge pwm_clk);
        tests++;
        if (pwm_out !== 4'b0001) begin
            fails++;
            $display("FAIL pre_reset_run pwm_out=%b exp 0001", pwm_out);
        end
        clk_run = 1'b0;
        #2 rstn = 1'b0;
        #1;
        tests++;
        if (pwm_out !== 4'b0000 || end_of_period !== 1'b0) begin
            fails++;
            $display("FAIL async_reset pwm_out=%b eop=%b exp 0000/0", pwm_out, end_of_period);
        end
        enable   = 1'b0;
        polarity = 4'b0000;
        clk_run  = 1'b1;
        repeat (2) @(negedge pwm_clk);
        rstn = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge pwm_clk);
            tests++;
            if (pwm_out !== 4'b0000 || end_of_period !== 1'b0) begin
                fails++;
                $display("FAIL post_release j=%0d pwm_out=%b eop=%b exp 0000/0", j, pwm_out, end_of_period);
            end
        end
    endtask

    task automatic test_edge;
        logic [CH-1:0] e;
        int c;
        idle_cfg(1'b0, 12'd9, {12'd12, 12'd10, 12'd0, 12'd3}, 4'b0000);
        enable = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge pwm_clk);
            c = j % 10;
            e = {1'b1, 1'b1, 1'b0, (c < 3)};
            tests++;
            if (pwm_out !== e || end_of_period !== (c == 9)) begin
                fails++;
                $display("FAIL edge j=%0d pwm_out=%b eop=%b exp %b/%b", j, pwm_out, end_of_period, e, (c == 9));
            end
        end
    endtask

    task automatic test_centre;
        logic [CH-1:0] e;
        int c;
        idle_cfg(1'b1, 12'd4, {36'd0, 12'd2}, 4'b0000);
        enable = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge pwm_clk);
            c = cseq[j % 8];
            e = {3'b000, (c < 2)};
            tests++;
            if (pwm_out !== e || end_of_period !== ((j % 8) == 7)) begin
                fails++;
                $display("FAIL centre j=%0d pwm_out=%b eop=%b exp %b/%b", j, pwm_out, end_of_period, e, ((j % 8) == 7));
            end
        end
        idle_cfg(1'b1, 12'd0, {36'd0, 12'd2}, 4'b0000);
        enable = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge pwm_clk);
            tests++;
            if (pwm_out !== 4'b0001 || end_of_period !== 1'b1) begin
                fails++;
                $display("FAIL period_zero j=%0d pwm_out=%b eop=%b exp 0001/1", j, pwm_out, end_of_period);
            end
        end
    endtask

    task automatic test_shadow;
        logic e0;
        logic ee;
        idle_cfg(1'b0, 12'd9, {36'd0, 12'd3}, 4'b0000);
        enable = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge pwm_clk);
            if (j < 10) begin
                e0 = (j < 3);
                ee = (j == 9);
            end else begin
                e0 = 1'b1;
                ee = (((j - 10) % 5) == 4);
            end
            tests++;
            if (pwm_out !== {3'b000, e0} || end_of_period !== ee) begin
                fails++;
                $display("FAIL shadow j=%0d pwm_out=%b eop=%b exp %b/%b", j, pwm_out, end_of_period, {3'b000, e0}, ee);
            end
            if (j == 4) begin
                duty   = {36'd0, 12'd7};
                period = 12'd4;
            end
        end
    endtask

    task automatic test_polarity_enable;
        logic [CH-1:0] e;
        int c;
        idle_cfg(1'b0, 12'd9, {24'd0, 12'd3, 12'd0}, 4'b0010);
        enable = 1'b1;
        for (int j = 0; j < 15; j++) begin
            @(negedge pwm_clk);
            c = j % 10;
            e = {2'b00, !(c < 3), 1'b0};
            tests++;
            if (pwm_out !== e || end_of_period !== (c == 9)) begin
                fails++;
                $display("FAIL polarity j=%0d pwm_out=%b eop=%b exp %b/%b", j, pwm_out, end_of_period, e, (c == 9));
            end
        end
        enable = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge pwm_clk);
            tests++;
            if (pwm_out !== 4'b0010 || end_of_period !== 1'b0) begin
                fails++;
                $display("FAIL disabled j=%0d pwm_out=%b eop=%b exp 0010/0", j, pwm_out, end_of_period);
            end
        end
        enable = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge pwm_clk);
            e = {2'b00, !(j < 3), 1'b0};
            tests++;
            if (pwm_out !== e || end_of_period !== (j == 9)) begin
                fails++;
                $display("FAIL reenable j=%0d pwm_out=%b eop=%b exp %b/%b", j, pwm_out, end_of_period, e, (j == 9));
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [CH-1:0] e;
        int k;
        idle_cfg(1'b1, 12'd4, {36'd0, 12'd2}, 4'b1000);
        enable = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge pwm_clk);
            e = {1'b1, 2'b00, (cseq[j] < 2)};
            tests++;
            if (pwm_out !== e || end_of_period !== 1'b0) begin
                fails++;
                $display("FAIL pre_mid_reset j=%0d pwm_out=%b eop=%b exp %b/0", j, pwm_out, end_of_period, e);
            end
        end
        rstn = 1'b0;
        #1;
        tests++;
        if (pwm_out !== 4'b0000 || end_of_period !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset pwm_out=%b eop=%b exp 0000/0", pwm_out, end_of_period);
        end
        repeat (2) @(negedge pwm_clk);
        rstn = 1'b1;
        for (int j = 0; j < 4096 + 16; j++) begin
            @(negedge pwm_clk);
            tests++;
            if (j < 4096) begin
                if (pwm_out !== 4'b0000 || end_of_period !== (j == 4095)) begin
                    fails++;
                    $display("FAIL default_period j=%0d pwm_out=%b eop=%b exp 0000/%b", j, pwm_out, end_of_period, (j == 4095));
                end
            end else begin
                k = j - 4096;
                e = {1'b1, 2'b00, (cseq[k % 8] < 2)};
                if (pwm_out !== e || end_of_period !== ((k % 8) == 7)) begin
                    fails++;
                    $display("FAIL after_default k=%0d pwm_out=%b eop=%b exp %b/%b", k, pwm_out, end_of_period, e, ((k % 8) == 7));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_centre();
        test_shadow();
        test_polarity_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
